// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT pipeline stages: state encoding,
// the rounding shift used by scaled stages, and a constant-safe clog2.
package fft_pkg;

  // Stage FSM encoding; kept as plain constants for legacy tool flows.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Ceiling log2, usable in constant expressions such as port widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Divide by two with round-half-up: (v + 1) >>> 1, arithmetic shift.
  // Callers sign-extend into 64 bits and cast the result to their width.
  function automatic logic signed [63:0] round_shr1(input logic signed [63:0] v);
    return (v + 64'sd1) >>> 1;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Feedback FIFO of DELAY words for an R2SDF stage. A single pointer
// addresses the head: every enabled cycle reads the head and overwrites it,
// so the word written now comes back exactly DELAY steps later.
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int W     = 34,
  parameter int DELAY = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data
);

  localparam int AW = clog2(DELAY);

  logic [AW-1:0] ptr;

  // Advance the shared read/write pointer once per step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) ptr <= '0;
    else if (en) ptr <= ptr + AW'(1);
  end

  if (DELAY <= 16) begin : g_regs
    logic [W-1:0] mem [DELAY];

    assign rd_data = mem[ptr];

    // Shallow lines live in flops with a combinational head read.
    always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; stale words are never emitted
      // because the stage's pending flag gates them, and resetting would stop
      // deep lines from mapping onto RAM.
      if (en) mem[ptr] <= wr_data;
    end
  end else begin : g_sram
    logic [W-1:0]  mem [DELAY];
    logic [W-1:0]  rd_q;
    logic [AW-1:0] rd_addr;

    // Prefetch the word that will be the head next cycle. The write address
    // (ptr) and the prefetch address (ptr+1) differ whenever en is high.
    assign rd_addr = rst ? '0 : (en ? ptr + AW'(1) : ptr);
    assign rd_data = rd_q;

    // Deep lines use a simple dual-port RAM with a registered read.
    always_ff @(posedge clk) begin
      if (en) mem[ptr] <= wr_data;
      rd_q <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 single-path-delay-feedback DIF butterfly stage. First half-block
// samples are parked in the delay line; second-half samples meet them to
// emit sums immediately and park the differences, which are emitted during
// the next block's first half (or during an explicit drain).
module fft_sdf_stage
  import fft_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DELAY = 1024,
  parameter int SCALE = 0,
  parameter int OW    = DW + 1 - SCALE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DW-1:0]      D_re,
  input  logic signed [DW-1:0]      D_im,
  input  logic                      flush,
  output logic                      out_valid,
  output logic signed [OW-1:0]      O_re,
  output logic signed [OW-1:0]      O_im,
  output logic [clog2(DELAY)-1:0]   out_idx,
  output logic                      out_half
);

  localparam int IW = clog2(DELAY);
  localparam int CW = IW + 1;
  localparam int WW = DW + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DELAY - 1);

  typedef struct packed {
    logic signed [WW-1:0] re;
    logic signed [WW-1:0] im;
  } wide_t;

  logic [CW-1:0]         cnt;
  logic                  pending;
  logic [0:0]            state;
  logic                  phase;
  logic [IW-1:0]         idx;
  logic                  go_drain;
  logic                  step;
  logic                  res_valid;
  wide_t                 x, head, sum, dif, wr, res;
  logic signed [OW-1:0]  o_re_n, o_im_n;

  assign phase    = cnt[CW-1];
  assign idx      = cnt[IW-1:0];
  assign in_ready = (state == ST_RUN);

  // A flush only takes effect on a block boundary with differences waiting;
  // it then wins over a simultaneous input, which is left unaccepted.
  assign go_drain = (state == ST_RUN) && flush && (cnt == '0) && pending;
  assign step     = (state == ST_DRAIN) || (in_valid && !go_drain);

  // Drain steps push zeros so the parked differences flow out unchanged.
  assign x.re = (state == ST_DRAIN) ? '0 : WW'(D_re);
  assign x.im = (state == ST_DRAIN) ? '0 : WW'(D_im);

  // One extra bit of headroom makes sum and difference overflow-free.
  assign sum.re = head.re + x.re;
  assign sum.im = head.im + x.im;
  assign dif.re = head.re - x.re;
  assign dif.im = head.im - x.im;

  fft_delay_line #(
    .W     (2 * WW),
    .DELAY (DELAY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .en      (step),
    .wr_data (wr),
    .rd_data (head)
  );

  // Butterfly routing: park input / emit difference in phase 0,
  // emit sum / park difference in phase 1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    wr        = x;
    res       = head;
    res_valid = pending;
    if (phase) begin
      wr        = dif;
      res       = sum;
      res_valid = 1'b1;
    end
  end

  // Optional per-stage 1-bit scaling with round-half-up.
  always_comb begin
    if (SCALE != 0) begin
      o_re_n = OW'(round_shr1(64'(res.re)));
      o_im_n = OW'(round_shr1(64'(res.im)));
    end else begin
      o_re_n = OW'(res.re);
      o_im_n = OW'(res.im);
    end
  end

  // Counter, pending flag, RUN/DRAIN FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pending   <= 1'b0;
      state     <= ST_RUN;
      out_valid <= 1'b0;
      O_re      <= '0;
      O_im      <= '0;
      out_idx   <= '0;
      out_half  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (go_drain) state <= ST_DRAIN;
      if (step) begin
        out_valid <= res_valid;
        O_re      <= o_re_n;
        O_im      <= o_im_n;
        out_idx   <= idx;
        out_half  <= ~phase;
        if (state == ST_DRAIN && idx == IDX_LAST) begin
          // Drain complete: next accepted sample starts a fresh block.
          state   <= ST_RUN;
          pending <= 1'b0;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
          if (phase && idx == IDX_LAST) pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Self-checking bench for fft_sdf_stage with DELAY=4, DW=16. Two instances
// (full growth and scaled) see identical stimulus and are compared against
// a block-level model: sums of x[n] and x[n+DELAY] now, differences later.
module tb_fft_sdf_stage;

  localparam int DW = 16;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic signed [DW-1:0] d_re = '0;
  logic signed [DW-1:0] d_im = '0;

  logic rdy0, rdy1, ov0, ov1, oh0, oh1;
  logic [1:0] oi0, oi1;
  logic signed [DW:0]   ore0, oim0;
  logic signed [DW-1:0] ore1, oim1;

  fft_sdf_stage #(.DW(DW), .DELAY(D), .SCALE(0)) u_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .D_re(d_re), .D_im(d_im), .flush(flush), .out_valid(ov0),
    .O_re(ore0), .O_im(oim0), .out_idx(oi0), .out_half(oh0)
  );

  fft_sdf_stage #(.DW(DW), .DELAY(D), .SCALE(1)) u_half (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .D_re(d_re), .D_im(d_im), .flush(flush), .out_valid(ov1),
    .O_re(ore1), .O_im(oim1), .out_idx(oi1), .out_half(oh1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Block-level reference model.
  longint m_a_re[D], m_a_im[D];     // first-half samples of the current block
  longint m_dc_re[D], m_dc_im[D];   // differences of the current block
  longint m_dp_re[D], m_dp_im[D];   // differences awaiting emission
  int     m_k, m_dn;
  bit     m_pending, m_drain;
  bit     e_valid, e_half;
  int     e_idx;
  longint e_re, e_im;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input longint v);
    return (v + 1) >>> 1;
  endfunction

  task automatic model_reset();
    m_k = 0; m_dn = 0; m_pending = 0; m_drain = 0;
    e_valid = 0; e_half = 0; e_idx = 0; e_re = 0; e_im = 0;
  endtask

  task automatic check_out(input string tag, input bit all_fields);
    check({tag, " valid_full"}, ov0, e_valid);
    check({tag, " valid_half"}, ov1, e_valid);
    if (e_valid || all_fields) begin
      check({tag, " re_full"},  ore0, e_re);
      check({tag, " im_full"},  oim0, e_im);
      check({tag, " re_half"},  ore1, rnd(e_re));
      check({tag, " im_half"},  oim1, rnd(e_im));
      check({tag, " idx_full"}, oi0, e_idx);
      check({tag, " idx_half"}, oi1, e_idx);
      check({tag, " half_full"}, oh0, e_half);
      check({tag, " half_half"}, oh1, e_half);
    end
  endtask

  // One clock: check ready, drive inputs, advance the model, check outputs.
  task automatic cycle(input string tag, input bit v, input longint re,
                       input longint im, input bit fl, input bit r = 1'b0);
    int j;
    check({tag, " ready_full"}, rdy0, !m_drain);
    check({tag, " ready_half"}, rdy1, !m_drain);
    in_valid = v; d_re = DW'(re); d_im = DW'(im); flush = fl; rst = r;
    e_valid = 0;
    if (r) begin
      model_reset();
    end else if (m_drain) begin
      e_valid = 1; e_half = 1; e_idx = m_dn;
      e_re = m_dp_re[m_dn]; e_im = m_dp_im[m_dn];
      m_dn++;
      if (m_dn == D) begin m_drain = 0; m_pending = 0; m_k = 0; end
    end else if (fl && m_k == 0 && m_pending) begin
      m_drain = 1; m_dn = 0;
    end else if (v) begin
      if (m_k < D) begin
        e_valid = m_pending; e_half = 1; e_idx = m_k;
        e_re = m_dp_re[m_k]; e_im = m_dp_im[m_k];
        m_a_re[m_k] = re; m_a_im[m_k] = im;
      end else begin
        j = m_k - D;
        e_valid = 1; e_half = 0; e_idx = j;
        e_re = m_a_re[j] + re; e_im = m_a_im[j] + im;
        m_dc_re[j] = m_a_re[j] - re; m_dc_im[j] = m_a_im[j] - im;
        if (m_k == 2 * D - 1) begin
          m_pending = 1; m_dp_re = m_dc_re; m_dp_im = m_dc_im;
        end
      end
      m_k = (m_k + 1) % (2 * D);
    end
    @(posedge clk);
    #1;
    in_valid = 0; flush = 0; rst = 0;
    check_out(tag, r);
  endtask

  initial begin
    bit v;
    int i;
    longint a, b;

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_out("reset", 1'b1);
    check("reset ready_full", rdy0, 1'b1);
    check("reset ready_half", rdy1, 1'b1);

    // Basic butterfly 1..8, then a zero block exposing differences of -4.
    for (int k = 1; k <= 8; k++) cycle("basic", 1'b1, k, 0, 1'b0);
    for (int k = 0; k < 8; k++) cycle("zeros", 1'b1, 0, 0, 1'b0);

    // Block 1..8, then flush together with a valid input (flush wins);
    // inputs during drain are ignored, then a fresh block with no valids.
    for (int k = 1; k <= 8; k++) cycle("preflush", 1'b1, k, -k, 1'b0);
    cycle("flush", 1'b1, 99, 99, 1'b1);
    for (int k = 0; k < D; k++) cycle("drain", 1'b1, 77, 77, 1'b0);
    for (int k = 1; k <= 8; k++) cycle("fresh", 1'b1, 10 * k, 3 - k, 1'b0);

    // Ignored flush at cnt=5, then reset during the 2nd drain cycle.
    for (int k = 0; k < 5; k++) cycle("ign", 1'b1, k, k, 1'b0);
    cycle("ign_flush", 1'b1, 5, 5, 1'b1);
    cycle("ign", 1'b1, 6, 6, 1'b0);
    cycle("ign", 1'b1, 7, 7, 1'b0);
    cycle("flush2", 1'b0, 0, 0, 1'b1);
    cycle("drain2", 1'b0, 0, 0, 1'b0);
    cycle("rst_drain", 1'b0, 0, 0, 1'b0, 1'b1);
    cycle("post_rst", 1'b0, 0, 0, 1'b0);

    // Extremes with random stalls: rounding of 65534 and -65536.
    i = 0;
    while (i < 16) begin
      v = 1'(($urandom_range(0, 1)));
      cycle("sat", v, 32767, -32768, 1'b0);
      if (v) i++;
    end

    // -3 against 0 rounds to -1 in the scaled stage.
    i = 0;
    while (i < 8) begin
      v = 1'(($urandom_range(0, 1)));
      cycle("neg3", v, (i < D) ? -3 : 0, (i < D) ? 0 : -3, 1'b0);
      if (v) i++;
    end

    // Random traffic with occasional flush requests.
    for (int k = 0; k < 120; k++) begin
      a = longint'($urandom_range(0, 65535)) - 32768;
      b = longint'($urandom_range(0, 65535)) - 32768;
      cycle("rand", ($urandom_range(0, 3) != 0), a, b,
            ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
